// File: rtl/seq_event_logger.sv
// seq_event_logger: timestamps detector pulses into a FWFT FIFO with saturating count and sticky overflow
module seq_event_logger #(
  parameter int TS_W  = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       z,
  input  logic                       clr,
  input  logic                       rd_en,
  output logic [TS_W-1:0]            rd_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     level,
  output logic [CNT_W-1:0]           total,
  output logic                       overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [TS_W-1:0] ts;
  logic [TS_W-1:0] mem [DEPTH];
  logic [AW-1:0]   wp, rp;
  logic            pop, push;
  assign pop     = rd_en && !empty;
  // a pop frees the slot this same edge, so a full FIFO still accepts the push
  assign push    = z && (!full || pop);
  assign empty   = level == '0;
  assign full    = level == LW'(DEPTH);
  assign rd_data = mem[rp];
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ts       <= '0;
      wp       <= '0;
      rp       <= '0;
      level    <= '0;
      total    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      ts <= ts + 1'b1;
      if (clr) begin
        wp       <= '0;
        rp       <= '0;
        level    <= '0;
        total    <= '0;
        overflow <= 1'b0;
      end else begin
        if (push) begin
          mem[wp] <= ts;
          wp      <= wp + 1'b1;
        end
        if (pop) rp <= rp + 1'b1;
        level <= level + LW'(push) - LW'(pop);
        if (z && total != '1) total <= total + 1'b1;
        if (z && full && !pop) overflow <= 1'b1;
      end
    end
  end
endmodule

// File: doc/seq_event_logger.md
# seq_event_logger

Downstream consumer of the Mealy non-overlapping sequence detector. It samples the detector's one-cycle `z` pulse and timestamps every detection with a free-running cycle counter. Timestamps go into a small first-word-fall-through FIFO, which a host or bench drains with a read strobe. It also keeps a saturating total-detection count and a sticky overflow flag, so no detection is lost silently.

## Interface
- `TS_W`, 8: timestamp width in bits; counter wraps modulo 2^TS_W.
- `DEPTH`, 4: FIFO entries; power of two, ≥ 2.
- `CNT_W`, 8: width of the total-detection counter.

Ports:
- `clk` in 1: single clock, all state updates on rising edge.
- `reset` in 1: asynchronous, active-low; low forces all state to reset values immediately.
- `z` in 1: detection pulse from sequence detector, sampled every rising edge.
- `clr` in 1: synchronous clear of FIFO, counters (except timestamp) and overflow.
- `rd_en` in 1: pop head entry; ignored while `empty`=1.
- `rd_data` out TS_W: head timestamp; meaningful only while `empty`=0.
- `empty` out 1: FIFO holds no entries.
- `full` out 1: FIFO holds DEPTH entries.
- `level` out $clog2(DEPTH)+1: current entry count, 0..DEPTH.
- `total` out CNT_W: detections seen since reset/clr, saturates at all-ones.
- `overflow` out 1: sticky; set when a detection is dropped.

## Operation
- Reset values: `empty`=1, `full`=0, `level`=0, `total`=0, `overflow`=0, `rd_data`=0, timestamp counter `ts`=0, read/write pointers 0.
- `ts`: increments by 1 every rising edge with `reset` high, wraps 2^TS_W−1 → 0. It is unaffected by `clr`.
- Push: `z`=1 at an edge writes the pre-increment value of `ts` at the tail.
- Pop: `rd_en`=1 with `empty`=0 advances the read pointer. `rd_data` shows the entry at the read pointer, read combinationally from registered storage (FWFT).
- Push when not full: entry is stored, `level`+1.
- Push when full, no pop: entry is dropped, `overflow`←1, `level` unchanged.
- Push and pop in the same cycle, with `level` ≥ 1 (including full): both occur, `level` unchanged, no overflow.
- Push and pop in the same cycle while empty: the pop is ignored and the push occurs.
- `total`: +1 on every sampled `z`=1, including dropped ones. It holds at 2^CNT_W−1 once reached.
- `clr`=1 has priority over everything:
  - Pointers, `level`, `total` and `overflow` go to 0; `empty`=1.
  - A `z` or `rd_en` in the same cycle is discarded.
- Pointers wrap modulo DEPTH. `full` and `empty` are derived from `level`, not pointer equality alone.
- `reset` low mid-operation: immediate return to reset values, queued entries lost. The first edge after `reset` rises counts as `ts`=0.

## Timing
- Latency from `z` sampled high to entry visible: 1 cycle. `empty` falls and `rd_data` is valid after that edge.
- Pop latency: `rd_data` updates to the next entry after the same edge that samples `rd_en`.
- `empty`, `full`, `level`, `total` and `overflow` are all registered and change only on `clk` edges or `reset` assertion.
- Back-to-back `z` on consecutive cycles are all logged (one per cycle); there is no merging.
- No combinational path from `z` or `rd_en` to any output.

## Test plan
Default parameters: TS_W=8, DEPTH=4, CNT_W=8.

- Reset: hold `reset`=0 with `z`=1 and `rd_en`=1 → `empty`=1, `full`=0, `level`=0, `total`=0, `overflow`=0, `rd_data`=0 throughout.
- Single event: release reset, pulse `z` at the edge where `ts`=5 → next cycle `rd_data`=5, `level`=1, `total`=1. Then one `rd_en` cycle → `empty`=1, `level`=0.
- Fill and overflow: `z`=1 at `ts`=10..14 with no reads → `full`=1 after the 4th edge; 5th dropped, `overflow`=1, `total`=5. Four pops read 10, 11, 12, 13, then `empty`=1; `overflow` stays 1.
- Full with simultaneous push/pop: fill with 20..23, then `z`=1 and `rd_en`=1 at `ts`=24 → `level`=4, `overflow`=0. Subsequent pops read 21, 22, 23, 24.
- Timestamp wrap and saturation:
  - Events at `ts`=255 and the next cycle → entries 255 then 0.
  - 260 events → `total`=255 and holds.
- Clear and async reset mid-operation:
  - With 2 entries queued, assert `clr` together with `z` → `level`=0, `total`=0, `empty`=1, and the `z` is not logged.
  - Later, drop `reset` between edges with 3 entries queued → outputs return to reset values without waiting for `clk`.
